// File: rtl/drain_pkg.sv
// drain_pkg
//   Shared definitions for the FIFO burst-drain block: the controller state
//   encoding and the default word width / burst length used by the top level.
//   No ports; imported by fifo_burst_drain.
package drain_pkg;

  localparam int DFLT_DATA_W    = 16;
  localparam int DFLT_BURST_LEN = 256;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_LATCH   = 3'd2,
    S_PRESENT = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } drain_state_t;

endpackage

// File: rtl/handshake_timer.sv
// handshake_timer
//   Phase counter that bounds how long one handshake phase may last.
//   Ports:
//     clk     - clock
//     reset_n - asynchronous active-low reset
//     clear   - restart the count from zero (takes priority over enable)
//     enable  - count one cycle spent in a guarded phase
//     expire  - high in the cycle whose count reaches ACK_TIMEOUT-1
module handshake_timer #(
  parameter int ACK_TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] count_reg;

  // Count holds at LAST so a late clear still restarts cleanly and the
  // counter can never wrap back into the valid range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain
//   Drains one burst of BURST_LEN words from a non-showahead FIFO once it is
//   full and the CPU has armed the block, presenting each word to the CPU
//   under a 4-phase valid/ack handshake with a per-phase timeout.
//   Ports:
//     clk, reset_n          - clock, asynchronous active-low reset
//     fifo_rdfull/rdempty   - FIFO read-side flags
//     fifo_q                - FIFO data, valid the cycle after fifo_rdreq
//     fifo_rdreq            - single-cycle read strobe
//     cpu_arm, cpu_ack      - CPU PIO levels (arm next burst, acknowledge)
//     cpu_data, cpu_valid   - word offered to the CPU and its valid flag
//     burst_done            - sticky, last burst finished normally
//     timeout_err           - sticky, last burst aborted on a handshake timeout
//     word_cnt              - words acknowledged in the current/last burst
//     busy                  - controller is not idle
module fifo_burst_drain
  import drain_pkg::*;
#(
  parameter int DATA_W      = DFLT_DATA_W,
  parameter int BURST_LEN   = DFLT_BURST_LEN,
  parameter int CNT_W       = 9,
  parameter int ACK_TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_rdfull,
  input  logic              fifo_rdempty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  input  logic              cpu_arm,
  input  logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_valid,
  output logic              burst_done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

  drain_state_t      state_reg, state_next;
  logic              arm_reg, ack_reg;
  logic              seen_low_reg, seen_low_next;
  logic [DATA_W-1:0] cpu_data_reg, cpu_data_next;
  logic              cpu_valid_reg, cpu_valid_next;
  logic              burst_done_reg, burst_done_next;
  logic              timeout_err_reg, timeout_err_next;
  logic [CNT_W-1:0]  word_cnt_reg, word_cnt_next;

  logic ack_accept;
  logic timer_clear, timer_enable, timer_expire;

  // An ack only counts once ack_r has been seen low in this PRESENT phase,
  // so a CPU that still holds ack high from earlier cannot skip a word.
  assign ack_accept   = (state_reg == S_PRESENT) && ack_reg && seen_low_reg;

  // Restart the phase counter on the way into PRESENT (from LATCH) and into
  // RELEASE (the accepted-ack cycle).
  assign timer_clear  = (state_reg == S_LATCH) || ack_accept;
  assign timer_enable = (state_reg == S_PRESENT) || (state_reg == S_RELEASE);

  handshake_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expire  (timer_expire)
  );

  always_comb begin
    state_next       = state_reg;
    seen_low_next    = seen_low_reg;
    cpu_data_next    = cpu_data_reg;
    cpu_valid_next   = cpu_valid_reg;
    burst_done_next  = burst_done_reg;
    timeout_err_next = timeout_err_reg;
    word_cnt_next    = word_cnt_reg;

    case (state_reg)
      S_IDLE: begin
        // Full implies non-empty; the empty term just keeps RD unreachable
        // if the flags ever disagree.
        if (arm_reg && fifo_rdfull && !fifo_rdempty) begin
          burst_done_next  = 1'b0;
          timeout_err_next = 1'b0;
          word_cnt_next    = '0;
          state_next       = S_RD;
        end
      end

      S_RD: begin
        state_next = S_LATCH;
      end

      S_LATCH: begin
        cpu_data_next  = fifo_q;
        cpu_valid_next = 1'b1;
        seen_low_next  = 1'b0;
        state_next     = S_PRESENT;
      end

      S_PRESENT: begin
        if (!ack_reg) begin
          seen_low_next = 1'b1;
        end
        if (ack_accept) begin
          cpu_valid_next = 1'b0;
          if (word_cnt_reg != BURST_CNT) begin
            word_cnt_next = word_cnt_reg + 1'b1;
          end
          state_next = S_RELEASE;
        end else if (timer_expire) begin
          // The word already pulled from the FIFO is dropped.
          cpu_valid_next   = 1'b0;
          timeout_err_next = 1'b1;
          state_next       = S_IDLE;
        end
      end

      S_RELEASE: begin
        if (!ack_reg) begin
          if ((word_cnt_reg == BURST_CNT) || fifo_rdempty) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RD;
          end
        end else if (timer_expire) begin
          timeout_err_next = 1'b1;
          state_next       = S_IDLE;
        end
      end

      S_DONE: begin
        burst_done_next = 1'b1;
        state_next      = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      arm_reg         <= 1'b0;
      ack_reg         <= 1'b0;
      seen_low_reg    <= 1'b0;
      cpu_data_reg    <= '0;
      cpu_valid_reg   <= 1'b0;
      burst_done_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      word_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      arm_reg         <= cpu_arm;
      ack_reg         <= cpu_ack;
      seen_low_reg    <= seen_low_next;
      cpu_data_reg    <= cpu_data_next;
      cpu_valid_reg   <= cpu_valid_next;
      burst_done_reg  <= burst_done_next;
      timeout_err_reg <= timeout_err_next;
      word_cnt_reg    <= word_cnt_next;
    end
  end

  assign fifo_rdreq  = (state_reg == S_RD);
  assign busy        = (state_reg != S_IDLE);
  assign cpu_data    = cpu_data_reg;
  assign cpu_valid   = cpu_valid_reg;
  assign burst_done  = burst_done_reg;
  assign timeout_err = timeout_err_reg;
  assign word_cnt    = word_cnt_reg;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain
//   Directed bench for fifo_burst_drain: a behavioural non-showahead FIFO,
//   a CPU handshake driver and hand-computed expectations.
module tb_fifo_burst_drain;

  localparam int DATA_W      = 16;
  localparam int BURST_LEN   = 256;
  localparam int CNT_W       = 9;
  localparam int ACK_TIMEOUT = 64;
  localparam int FIFO_DEPTH  = 256;
  localparam int WAIT_BOUND  = 300;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fifo_rdfull;
  logic              fifo_rdempty;
  logic [DATA_W-1:0] fifo_q = '0;
  logic              fifo_rdreq;
  logic              cpu_arm = 1'b0;
  logic              cpu_ack = 1'b0;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_valid;
  logic              burst_done;
  logic              timeout_err;
  logic [CNT_W-1:0]  word_cnt;
  logic              busy;

  always #5 clk = ~clk;

  fifo_burst_drain #(
    .DATA_W      (DATA_W),
    .BURST_LEN   (BURST_LEN),
    .CNT_W       (CNT_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_rdfull  (fifo_rdfull),
    .fifo_rdempty (fifo_rdempty),
    .fifo_q       (fifo_q),
    .fifo_rdreq   (fifo_rdreq),
    .cpu_arm      (cpu_arm),
    .cpu_ack      (cpu_ack),
    .cpu_data     (cpu_data),
    .cpu_valid    (cpu_valid),
    .burst_done   (burst_done),
    .timeout_err  (timeout_err),
    .word_cnt     (word_cnt),
    .busy         (busy)
  );

  // ---------------- FIFO model (non-showahead) ----------------
  logic [DATA_W-1:0] fifo_mem [0:FIFO_DEPTH-1];
  int   rd_ptr = 0;
  int   wr_ptr = 0;
  int   fill_count = 0;
  logic fifo_load = 1'b0;
  logic full_force = 1'b0;

  always @(posedge clk) begin
    if (fifo_load) begin
      rd_ptr <= 0;
      wr_ptr <= fill_count;
    end else if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
      fifo_q <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  assign fifo_rdempty = (rd_ptr == wr_ptr);
  assign fifo_rdfull  = full_force || ((wr_ptr - rd_ptr) == FIFO_DEPTH);

  int rdreq_cnt = 0;
  int rd_empty_viol = 0;
  always @(posedge clk) begin
    if (fifo_rdreq) rdreq_cnt <= rdreq_cnt + 1;
    if (fifo_rdreq && fifo_rdempty) rd_empty_viol <= rd_empty_viol + 1;
  end

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_fifo(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_mem[i] = DATA_W'(base + i);
    fill_count = n;
    fifo_load  = 1'b1;
    @(negedge clk);
    fifo_load  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input logic lvl, input string tag);
    int n = 0;
    while (cpu_valid !== lvl && n < WAIT_BOUND) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, cpu_valid}, {31'd0, lvl});
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (busy !== lvl && n < WAIT_BOUND) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  // One full 4-phase handshake: ack 3 cycles after valid, release 3 cycles
  // after valid drops.
  task automatic cpu_word(input int idx, input int exp);
    wait_valid(1'b1, $sformatf("word%0d_valid_up", idx));
    check($sformatf("word%0d_data", idx), {16'd0, cpu_data}, 32'(exp) & 32'h0000_FFFF);
    $display("[TB] word %0d data 0x%04h", idx, cpu_data);
    repeat (3) @(negedge clk);
    cpu_ack = 1'b1;
    wait_valid(1'b0, $sformatf("word%0d_valid_dn", idx));
    repeat (3) @(negedge clk);
    cpu_ack = 1'b0;
  endtask

  initial begin
    int n;
    int rd0;
    logic [DATA_W-1:0] q;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, cpu_valid}, 0);
    check("rst_data", {16'd0, cpu_data}, 0);
    check("rst_rdreq", {31'd0, fifo_rdreq}, 0);
    check("rst_done", {31'd0, burst_done}, 0);
    check("rst_terr", {31'd0, timeout_err}, 0);
    check("rst_wcnt", {23'd0, word_cnt}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset released");

    // ---------------- basic burst + latency ----------------
    load_fifo(256, 0);
    rd0 = rdreq_cnt;
    cpu_arm = 1'b1;
    n = 0;
    while (fifo_rdreq !== 1'b1 && n < WAIT_BOUND) begin
      @(negedge clk);
      n++;
    end
    check("lat_rdreq", {31'd0, fifo_rdreq}, 1);
    cpu_arm = 1'b0;
    @(negedge clk);
    q = fifo_q;
    check("lat_valid_n1", {31'd0, cpu_valid}, 0);
    @(negedge clk);
    check("lat_valid_n2", {31'd0, cpu_valid}, 1);
    check("lat_data_eq_q", {16'd0, cpu_data}, {16'd0, q});
    check("lat_q_first", {16'd0, q}, 0);
    $display("[TB] latency: rdreq->valid 2 cycles, data 0x%04h", cpu_data);
    for (int i = 0; i < 256; i++) cpu_word(i, i);
    wait_busy(1'b0, "basic_idle");
    check("basic_wcnt", {23'd0, word_cnt}, 256);
    check("basic_done", {31'd0, burst_done}, 1);
    check("basic_terr", {31'd0, timeout_err}, 0);
    check("basic_rdreqs", rdreq_cnt - rd0, 256);
    $display("[TB] basic burst: word_cnt=%0d done=%0d", word_cnt, burst_done);

    // ---------------- short burst (FIFO empties after 5) ----------------
    load_fifo(5, 'hA0);
    rd0 = rdreq_cnt;
    full_force = 1'b1;
    cpu_arm = 1'b1;
    wait_busy(1'b1, "short_start");
    full_force = 1'b0;
    cpu_arm = 1'b0;
    check("short_done_clr", {31'd0, burst_done}, 0);
    check("short_wcnt_clr", {23'd0, word_cnt}, 0);
    for (int i = 0; i < 5; i++) cpu_word(i, 'hA0 + i);
    wait_busy(1'b0, "short_idle");
    check("short_wcnt", {23'd0, word_cnt}, 5);
    check("short_done", {31'd0, burst_done}, 1);
    check("short_rdreqs", rdreq_cnt - rd0, 5);
    $display("[TB] short burst: word_cnt=%0d done=%0d", word_cnt, burst_done);

    // ---------------- timeout on word index 2 ----------------
    load_fifo(256, 'h100);
    cpu_arm = 1'b1;
    wait_busy(1'b1, "to_start");
    cpu_arm = 1'b0;
    cpu_word(0, 'h100);
    cpu_word(1, 'h101);
    wait_valid(1'b1, "to_word2_up");
    check("to_word2_data", {16'd0, cpu_data}, 'h102);
    n = 0;
    while (cpu_valid === 1'b1 && n < WAIT_BOUND) begin
      n++;
      @(negedge clk);
    end
    check("to_valid_cycles", n, ACK_TIMEOUT);
    check("to_terr", {31'd0, timeout_err}, 1);
    check("to_wcnt", {23'd0, word_cnt}, 2);
    check("to_busy", {31'd0, busy}, 0);
    check("to_done", {31'd0, burst_done}, 0);
    $display("[TB] timeout: valid high %0d cycles, word_cnt=%0d", n, word_cnt);

    // ---------------- stuck-high ack, then reset mid-burst ----------------
    load_fifo(256, 0);
    cpu_ack = 1'b1;
    cpu_arm = 1'b1;
    wait_busy(1'b1, "stuck_start");
    cpu_arm = 1'b0;
    check("stuck_terr_clr", {31'd0, timeout_err}, 0);
    wait_valid(1'b1, "stuck_valid_up");
    check("stuck_data", {16'd0, cpu_data}, 0);
    repeat (10) @(negedge clk);
    check("stuck_wcnt_hold", {23'd0, word_cnt}, 0);
    check("stuck_valid_hold", {31'd0, cpu_valid}, 1);
    cpu_ack = 1'b0;
    repeat (3) @(negedge clk);
    cpu_ack = 1'b1;
    wait_valid(1'b0, "stuck_valid_dn");
    check("stuck_wcnt_one", {23'd0, word_cnt}, 1);
    repeat (3) @(negedge clk);
    cpu_ack = 1'b0;
    $display("[TB] stuck ack: first word counted only after low-high");
    for (int i = 1; i < 10; i++) cpu_word(i, i);
    wait_valid(1'b1, "mid_word10_up");
    check("mid_word10_data", {16'd0, cpu_data}, 10);
    check("mid_wcnt", {23'd0, word_cnt}, 10);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, cpu_valid}, 0);
    check("arst_data", {16'd0, cpu_data}, 0);
    check("arst_rdreq", {31'd0, fifo_rdreq}, 0);
    check("arst_done", {31'd0, burst_done}, 0);
    check("arst_terr", {31'd0, timeout_err}, 0);
    check("arst_wcnt", {23'd0, word_cnt}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    $display("[TB] async reset mid-burst applied");
    @(negedge clk);
    reset_n = 1'b1;
    cpu_arm = 1'b1;
    rd0 = rdreq_cnt;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 0);
    check("post_rst_rdreqs", rdreq_cnt - rd0, 0);
    full_force = 1'b1;
    wait_busy(1'b1, "post_rst_restart");
    full_force = 1'b0;
    cpu_arm = 1'b0;
    check("no_rdreq_empty", rd_empty_viol, 0);
    #2 reset_n = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
